alu_multicycle: RTL and testbench

//  Parametrised successor to the single-cycle datapath ALU. It adds registered outputs, unsigned

---
 rtl/alu_multicycle_pkg.sv | 42 ++++
 rtl/alu_multicycle_muldiv_iter.sv | 145 ++++++++++++++
 rtl/alu_multicycle.sv | 89 ++++++++
 tb/tb_alu_multicycle.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multi-cycle ALU and the control unit that drives it.
//   op_e    : 4-bit ALU control codes
//   state_e : mul/div sequencer states (IDLE -> ITER -> FIX)
//   helpers : decode of the mul/div group from a raw control code
package alu_multicycle_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SLTU  = 4'b0011,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_MULT  = 4'b1000,
    OP_MULTU = 4'b1001,
    OP_DIV   = 4'b1010,
    OP_DIVU  = 4'b1011,
    OP_NOR   = 4'b1100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // 10xx is the multiply/divide group
  function automatic logic is_muldiv(input logic [3:0] code);
    return code[3:2] == 2'b10;
  endfunction

  // within the group, bit 1 selects divide
  function automatic logic is_div_op(input logic [3:0] code);
    return code[1];
  endfunction

  // within the group, bit 0 clear means signed
  function automatic logic is_signed_op(input logic [3:0] code);
    return ~code[0];
  endfunction

endpackage

// File: rtl/alu_multicycle_muldiv_iter.sv
// Iterative multiply / divide engine (one bit per clock).
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   go                  : accept a new mul/div op (operands sampled this edge)
//   div_op, signed_op   : op selection, valid with go
//   a, b                : multiplicand/dividend, multiplier/divisor
//   busy                : op in progress (ITER or FIX)
//   fix_valid           : FIX cycle; hi_fix/lo_fix are final this cycle
//   hi_fix, lo_fix      : sign-corrected upper/lower product or remainder/quotient
module alu_muldiv_iter
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             div_op,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fix_valid,
  output logic [WIDTH-1:0] hi_fix,
  output logic [WIDTH-1:0] lo_fix
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e state, state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;       // partial product high half / partial remainder
  logic [WIDTH-1:0] mq;        // multiplier shifting out / dividend in, quotient out
  logic [WIDTH-1:0] b_mag_q;
  logic [WIDTH-1:0] a_raw_q;   // unmodified dividend, returned as remainder on /0
  logic             div_q;
  logic             neg_q;     // negate product or quotient
  logic             neg_rem_q; // negate remainder (sign of dividend)
  logic             b_zero_q;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_diff;

  always_comb begin
    a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag = (signed_op && b[WIDTH-1]) ? -b : b;
  end

  // one step of shift-add and one step of restoring division
  always_comb begin
    mul_sum   = {1'b0, acc} + {1'b0, (mq[0] ? b_mag_q : {WIDTH{1'b0}})};
    div_shift = {acc, mq[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (go) state_next = ST_ITER;
      ST_ITER: if (count == LAST) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      acc       <= '0;
      mq        <= '0;
      b_mag_q   <= '0;
      a_raw_q   <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            count     <= '0;
            acc       <= '0;
            mq        <= a_mag;
            b_mag_q   <= b_mag;
            a_raw_q   <= a;
            div_q     <= div_op;
            neg_q     <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= signed_op & a[WIDTH-1];
            b_zero_q  <= (b == '0);
          end
        end
        ST_ITER: begin
          count <= count + 1'b1;
          if (div_q) begin
            if (!div_diff[WIDTH]) begin
              acc <= div_diff[WIDTH-1:0];
              mq  <= {mq[WIDTH-2:0], 1'b1};
            end else begin
              acc <= div_shift[WIDTH-1:0];
              mq  <= {mq[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= mul_sum[WIDTH:1];
            mq  <= {mul_sum[0], mq[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // sign correction applied during FIX; magnitude of most-negative/-1 is
  // already 2^(WIDTH-1) unsigned, so it wraps to most-negative naturally
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    prod     = {acc, mq};
    prod_fix = neg_q ? -prod : prod;
    quot     = neg_q ? -mq : mq;
    rem      = neg_rem_q ? -acc : acc;
    if (!div_q) begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end else if (b_zero_q) begin
      hi_fix = a_raw_q;
      lo_fix = '1;
    end else begin
      hi_fix = rem;
      lo_fix = quot;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign fix_valid = (state == ST_FIX);

endmodule

// File: rtl/alu_multicycle.sv
// EX-stage ALU with registered outputs and iterative mul/div into HI/LO.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   start, control    : issue op (ignored while busy), 4-bit op code
//   input_a, input_b  : operands
//   busy              : mul/div in progress
//   done              : one-cycle pulse when result (and hi/lo for mul/div) updates
//   result, zero      : registered result, and result == 0
//   hi, lo            : mul: upper/lower product; div: remainder/quotient
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             md_busy, fix_valid;
  logic [WIDTH-1:0] hi_fix, lo_fix;
  logic [WIDTH-1:0] alu_out;
  logic             accept, go;

  assign accept = start && !md_busy;
  assign go     = accept && is_muldiv(control);

  always_comb begin
    alu_out = '0;
    case (control)
      OP_ADD:  alu_out = input_a + input_b;
      OP_SUB:  alu_out = input_a - input_b;
      OP_SLT:  alu_out[0] = $signed(input_a) < $signed(input_b);
      OP_SLTU: alu_out[0] = input_a < input_b;
      OP_AND:  alu_out = input_a & input_b;
      OP_OR:   alu_out = input_a | input_b;
      OP_NOR:  alu_out = ~(input_a | input_b);
      default: alu_out = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clock     (clock),
    .reset     (reset),
    .go        (go),
    .div_op    (is_div_op(control)),
    .signed_op (is_signed_op(control)),
    .a         (input_a),
    .b         (input_b),
    .busy      (md_busy),
    .fix_valid (fix_valid),
    .hi_fix    (hi_fix),
    .lo_fix    (lo_fix)
  );

  // FIX and an accepted start never coincide: busy is high during FIX
  always_ff @(posedge clock) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      if (fix_valid) begin
        hi     <= hi_fix;
        lo     <= lo_fix;
        result <= lo_fix;
        done   <= 1'b1;
      end else if (accept && !is_muldiv(control)) begin
        result <= alu_out;
        done   <= 1'b1;
      end
    end
  end

  assign busy = md_busy;
  assign zero = (result == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    control = 4'b0;
  logic [W-1:0]  input_a = '0;
  logic [W-1:0]  input_b = '0;
  logic          busy, done, zero;
  logic [W-1:0]  result, hi, lo;

  alu_multicycle #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .control (control),
    .input_a (input_a),
    .input_b (input_b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic [W-1:0] l;
    int           due;
    int           blen;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_cnt = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // reference: plain arithmetic on the op definitions
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int due0);
    exp_t e;
    logic [63:0] p;
    int sa, sbv;
    e.op = op; e.due = due0; e.blen = 0;
    e.h = hi_m; e.l = lo_m; e.r = '0;
    sa = a; sbv = b;
    case (op)
      4'b0010: e.r = a + b;
      4'b0110: e.r = a - b;
      4'b0111: e.r = (sa < sbv) ? 1 : 0;
      4'b0011: e.r = (a < b) ? 1 : 0;
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b1100: e.r = ~(a | b);
      4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
        if (op == 4'b1000) begin
          p = longint'(sa) * longint'(sbv);
          e.h = p[63:32]; e.l = p[31:0];
        end else if (op == 4'b1001) begin
          p = {32'b0, a} * {32'b0, b};
          e.h = p[63:32]; e.l = p[31:0];
        end else if (b == 0) begin
          e.l = '1; e.h = a;
        end else if (op == 4'b1010) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.l = a; e.h = 0;
          end else begin
            e.l = sa / sbv; e.h = sa % sbv;
          end
        end else begin
          e.l = a / b; e.h = a % b;
        end
        e.r = e.l;
        e.due = due0 + W + 1;
        e.blen = W + 1;
      end
      default: e.r = '0;
    endcase
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {63'b0, done}, 64'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("result op=%b", e.op), {32'b0, result}, {32'b0, e.r});
          check($sformatf("hi op=%b", e.op), {32'b0, hi}, {32'b0, e.h});
          check($sformatf("lo op=%b", e.op), {32'b0, lo}, {32'b0, e.l});
          check($sformatf("zero op=%b", e.op), {63'b0, zero}, {63'b0, (e.r == 0)});
          check($sformatf("latency op=%b", e.op), 64'(cyc), 64'(e.due));
          check($sformatf("busy_len op=%b", e.op), 64'(busy_cnt), 64'(e.blen));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy) begin
      @(posedge clock); #1;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL wait_idle: busy stuck for %0d cycles, want <= %0d", n, W + 2);
        finish_run();
      end
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    wait_idle();
    control = op; input_a = a; input_b = b; start = 1'b1;
    e = model(op, a, b, cyc + 1);
    hi_m = e.h; lo_m = e.l;
    sb.push_back(e);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_opnd();
    logic [W-1:0] sp [5];
    sp[0] = 0; sp[1] = 1; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    if ($urandom_range(0, 2) == 0) return W'($urandom_range(0, 40)) - W'(20);
    return $urandom;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},   {63'b0, busy}, 64'd0);
    check({tag, "_done"},   {63'b0, done}, 64'd0);
    check({tag, "_result"}, {32'b0, result}, 64'd0);
    check({tag, "_hi"},     {32'b0, hi}, 64'd0);
    check({tag, "_lo"},     {32'b0, lo}, 64'd0);
    check({tag, "_zero"},   {63'b0, zero}, 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_reset_state("reset");

    // directed cases
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
    issue(4'b0110, 32'd5, 32'd5);
    issue(4'b0111, 32'hFFFF_FFFF, 32'h1);
    issue(4'b0011, 32'hFFFF_FFFF, 32'h1);
    issue(4'b1111, 32'h1234_5678, 32'h9);
    issue(4'b1100, 32'h0F0F_0000, 32'h0000_00F0);
    issue(4'b1000, -32'sd3, 32'd5);
    issue(4'b1010, -32'sd7, 32'd2);
    issue(4'b1011, 32'd7, 32'd0);
    issue(4'b1010, -32'sd9, 32'd0);
    issue(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'b0010, 32'd1, 32'd2);   // single-cycle right after a mul/div hi/lo hold

    // start while busy is ignored and operands are not re-latched
    issue(4'b1011, 32'd100, 32'd7);
    repeat (4) begin @(posedge clock); #1; end
    check("busy_at_plus5", {63'b0, busy}, 64'd1);
    control = 4'b1011; input_a = 32'd55; input_b = 32'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_idle();

    // reset in the middle of a multiply aborts it without a done
    wait_idle();
    control = 4'b1000; input_a = 32'd12345; input_b = 32'd6789; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    check_reset_state("abort");
    issue(4'b1000, 32'd12345, 32'd6789);

    // randomized stream, including invalid codes and back-to-back issue
    for (int i = 0; i < 250; i++) begin
      issue(4'($urandom_range(0, 15)), rand_opnd(), rand_opnd());
      if ($urandom_range(0, 4) == 0) begin @(posedge clock); #1; end
    end

    begin
      int n = 0;
      while (sb.size() != 0 && n < 100) begin @(posedge clock); #1; n++; end
    end
    check("pending_at_end", 64'(sb.size()), 64'd0);
    finish_run();
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, pending=%0d want 0", sb.size());
    bad++; total++;
    finish_run();
  end

endmodule
